// File: rtl/dcache_victim_buffer.sv
// Single-entry write-back victim buffer: captures one evicted dirty line and
// drains it as a single AXI INCR write burst, with a line-address lookup port.
module dcache_victim_buffer #(
   parameter int LINE_WORDS  = 8,
   parameter int OFFSET_BITS = $clog2(LINE_WORDS) + 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vb_push,
   output logic                     vb_ready,
   input  logic [31:0]              vb_addr,
   input  logic [LINE_WORDS*32-1:0] vb_data,
   input  logic [31:0]              lk_addr,
   output logic                     lk_hit,
   output logic                     busy,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [31:0]              awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic                     wvalid,
   input  logic                     wready,
   output logic [31:0]              wdata,
   output logic [3:0]               wstrb,
   output logic                     wlast,
   input  logic                     bvalid,
   output logic                     bready
);

   localparam int BW = $clog2(LINE_WORDS);
   localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

   state_t        state;
   logic          valid;
   logic [BW-1:0] beat;
   logic [BW-1:0] beat_nx;
   logic [31:0]   line [LINE_WORDS];
   logic          unused_offsets;

   assign awlen   = 8'(LINE_WORDS - 1);
   assign awsize  = 3'b010;
   assign awburst = 2'b01;
   assign wstrb   = 4'hF;
   assign beat_nx = beat + BW'(1);

   // awaddr doubles as the held line address, so the lookup compares against it
   assign lk_hit = valid && (lk_addr[31:OFFSET_BITS] == awaddr[31:OFFSET_BITS]);

   assign unused_offsets = ^{vb_addr[OFFSET_BITS-1:0], lk_addr[OFFSET_BITS-1:0]};

   always_ff @(posedge clk) begin
      if (state == IDLE && vb_push) begin
         for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            line[i] <= vb_data[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         valid    <= 1'b0;
         beat     <= '0;
         awaddr   <= '0;
         wdata    <= '0;
         vb_ready <= 1'b1;
         busy     <= 1'b0;
         awvalid  <= 1'b0;
         wvalid   <= 1'b0;
         wlast    <= 1'b0;
         bready   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (vb_push) begin
                  awaddr   <= {vb_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  valid    <= 1'b1;
                  vb_ready <= 1'b0;
                  busy     <= 1'b1;
                  awvalid  <= 1'b1;
                  state    <= AW;
               end
            end
            AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  beat    <= '0;
                  wvalid  <= 1'b1;
                  wdata   <= line[0];
                  wlast   <= (LINE_WORDS == 1);
                  state   <= W;
               end
            end
            W: begin
               // wdata/wlast are registered, so they are loaded one beat ahead
               if (wready) begin
                  if (beat == LAST) begin
                     wvalid <= 1'b0;
                     wlast  <= 1'b0;
                     bready <= 1'b1;
                     state  <= B;
                  end else begin
                     beat  <= beat_nx;
                     wdata <= line[beat_nx];
                     wlast <= (beat_nx == LAST);
                  end
               end
            end
            B: begin
               if (bvalid) begin
                  valid    <= 1'b0;
                  bready   <= 1'b0;
                  busy     <= 1'b0;
                  vb_ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Randomized self-checking bench for dcache_victim_buffer against a
// transaction-level model (held line, AW done flag, beats delivered).
module tb_dcache_victim_buffer;

   localparam int LW = 8;
   localparam int OB = $clog2(LW) + 2;

   logic             clk;
   logic             rst;
   logic             vb_push;
   logic             vb_ready;
   logic [31:0]      vb_addr;
   logic [LW*32-1:0] vb_data;
   logic [31:0]      lk_addr;
   logic             lk_hit;
   logic             busy;
   logic             awvalid;
   logic             awready;
   logic [31:0]      awaddr;
   logic [7:0]       awlen;
   logic [2:0]       awsize;
   logic [1:0]       awburst;
   logic             wvalid;
   logic             wready;
   logic [31:0]      wdata;
   logic [3:0]       wstrb;
   logic             wlast;
   logic             bvalid;
   logic             bready;

   dcache_victim_buffer #(.LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst),
      .vb_push(vb_push), .vb_ready(vb_ready), .vb_addr(vb_addr), .vb_data(vb_data),
      .lk_addr(lk_addr), .lk_hit(lk_hit), .busy(busy),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: one held line, progress tracked as "AW sent" and beats delivered
   bit          m_held;
   logic [31:0] m_addr;
   logic [31:0] m_data [LW];
   bit          m_aw_done;
   int          m_beats;
   int          bursts_done;

   // driven inputs for the next cycle
   bit               d_push;
   logic [31:0]      d_addr;
   logic [LW*32-1:0] d_data;
   logic [31:0]      d_lk;
   bit               d_rst;

   int mode;     // 0 zero-wait, 1 scripted back-pressure, 2 random slave
   int aw_wait;
   int b_wait;
   bit w_tog;
   bit s_ready;

   function automatic logic [LW*32-1:0] rand_line();
      logic [LW*32-1:0] v;
      for (int i = 0; i < LW; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic step();
      bit ea, ew, eb, ha, hw, hb;
      logic [31:0] mask;
      @(negedge clk);
      rst = d_rst; vb_push = d_push; vb_addr = d_addr; vb_data = d_data; lk_addr = d_lk;
      ea = m_held && !m_aw_done;
      ew = m_held && m_aw_done && (m_beats < LW);
      eb = m_held && (m_beats == LW);
      case (mode)
         0: begin awready = 1'b1; wready = 1'b1; bvalid = 1'b1; end
         1: begin awready = (aw_wait >= 3); wready = w_tog; bvalid = (b_wait >= 5); end
         default: begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = 1'($urandom_range(0, 1));
         end
      endcase
      #1;
      s_ready = vb_ready;
      chk("vb_ready", 32'(vb_ready), 32'(!m_held));
      chk("busy", 32'(busy), 32'(m_held));
      chk("awvalid", 32'(awvalid), 32'(ea));
      chk("wvalid", 32'(wvalid), 32'(ew));
      chk("bready", 32'(bready), 32'(eb));
      chk("lk_hit", 32'(lk_hit), 32'(m_held && (d_lk[31:OB] == m_addr[31:OB])));
      if (ea) begin
         chk("awaddr", awaddr, m_addr);
         chk("awlen", 32'(awlen), LW - 1);
         chk("awsize", 32'(awsize), 2);
         chk("awburst", 32'(awburst), 1);
      end
      if (ew) begin
         chk("wdata", wdata, m_data[m_beats]);
         chk("wlast", 32'(wlast), 32'(m_beats == LW - 1));
         chk("wstrb", 32'(wstrb), 32'hF);
      end else begin
         chk("wlast_idle", 32'(wlast), 0);
      end
      ha = ea && awready;
      hw = ew && wready;
      hb = eb && bvalid;
      mask = ~((32'h1 << OB) - 1);
      if (d_rst) begin
         m_held = 0; m_aw_done = 0; m_beats = 0;
      end else if (!m_held && d_push) begin
         m_held = 1; m_aw_done = 0; m_beats = 0;
         m_addr = d_addr & mask;
         for (int i = 0; i < LW; i++) m_data[i] = d_data[32*i +: 32];
      end else if (m_held) begin
         if (ha) m_aw_done = 1;
         if (hw) m_beats++;
         if (hb) begin m_held = 0; bursts_done++; end
      end
      if (ha || !ea) aw_wait = 0; else aw_wait++;
      if (hb || !eb) b_wait = 0; else b_wait++;
      w_tog = ew ? !w_tog : 1'b1;
      @(posedge clk);
   endtask

   task automatic drain(input string tag, input int bound);
      int n = 0;
      d_push = 0;
      while (m_held && n < bound) begin step(); n++; end
      if (m_held) chk({tag, "_timeout"}, 1, 0);
   endtask

   task automatic push_line(input logic [31:0] a, input logic [LW*32-1:0] d);
      d_push = 1; d_addr = a; d_data = d;
      step();
      d_push = 0;
   endtask

   initial begin
      logic [LW*32-1:0] l;
      int lat, b0;
      m_held = 0; m_aw_done = 0; m_beats = 0; m_addr = '0; bursts_done = 0;
      for (int i = 0; i < LW; i++) m_data[i] = '0;
      aw_wait = 0; b_wait = 0; w_tog = 1; mode = 0;
      d_push = 0; d_addr = '0; d_data = '0; d_lk = '0; d_rst = 1;
      rst = 1; vb_push = 0; vb_addr = '0; vb_data = '0; lk_addr = '0;
      awready = 0; wready = 0; bvalid = 0;

      // reset
      step(); step();
      #2;
      chk("rst_awaddr", awaddr, 0);
      chk("rst_wdata", wdata, 0);
      d_rst = 0;
      step();

      // basic drain, zero-wait slave, ready-again latency
      mode = 0;
      for (int i = 0; i < LW; i++) l[32*i +: 32] = 32'h11 * (i + 1);
      push_line(32'h1000_0024, l);
      lat = -1;
      for (int c = 1; c < 40 && lat < 0; c++) begin
         step();
         if (s_ready) lat = c;
      end
      chk("ready_latency", lat, LW + 3);

      // scripted back-pressure
      mode = 1;
      push_line(32'hABCD_1234, rand_line());
      drain("bp", 200);

      // lookup hit / miss on the same held line
      mode = 2;
      push_line(32'h2000_0040, rand_line());
      for (int n = 0; n < 200 && m_held; n++) begin
         d_lk = n[0] ? 32'h2000_0060 : 32'h2000_005C;
         step();
      end
      d_lk = 32'h2000_005C;
      step();

      // illegal pushes during W
      mode = 0;
      push_line(32'h3000_0100, rand_line());
      for (int n = 0; n < 100 && m_held; n++) begin
         d_push = m_aw_done && m_beats < LW;
         d_addr = 32'h4444_4440; d_data = rand_line();
         step();
      end
      d_push = 0;
      if (m_held) chk("illegal_timeout", 1, 0);

      // reset at beat 4, then a clean drain
      push_line(32'h5000_0080, rand_line());
      for (int n = 0; n < 50 && m_beats < 4; n++) step();
      d_rst = 1; d_lk = 32'h5000_0080;
      step();
      d_rst = 0;
      #2;
      chk("midrst_awaddr", awaddr, 0);
      step();
      push_line(32'h6000_00C0, rand_line());
      drain("post_rst", 100);

      // back-to-back: second push in the first cycle ready returns
      mode = 2;
      b0 = bursts_done;
      push_line(32'h7000_0000, rand_line());
      for (int n = 0; n < 300 && m_held; n++) begin
         d_push = 0; step();
      end
      d_addr = 32'h7000_0100; d_data = rand_line(); d_push = 1;
      step();
      drain("b2b", 300);
      chk("b2b_bursts", bursts_done - b0, 2);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         d_rst  = ($urandom_range(0, 199) == 0);
         d_push = m_held ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
         d_addr = $urandom;
         d_data = rand_line();
         d_lk   = $urandom_range(0, 1) ? (m_addr | 32'($urandom_range(0, 31))) : $urandom;
         step();
      end
      d_rst = 0;
      drain("final", 300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_victim_buffer.md
# dcache_victim_buffer

Single-entry write-back victim buffer for the data cache. When the replacement logic evicts a dirty line, the dcache pushes the whole line here in one cycle, and the buffer drains it to memory as one AXI INCR write burst. While a line is held, a line-address lookup port lets the miss path detect a pending victim and stall its refill, so stale memory data is never read.

## Interface
- LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16.
- OFFSET_BITS, $clog2(LINE_WORDS)+2, byte-offset bits ignored in line compares.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- vb_push  in  1  dcache presents an evicted dirty line
- vb_ready  out  1  buffer can accept a push this cycle
- vb_addr  in  32  line base address; low OFFSET_BITS ignored and forced to 0 internally
- vb_data  in  LINE_WORDS*32  line data; word i = vb_data[32*i+31 : 32*i]
- lk_addr  in  32  miss-path lookup address
- lk_hit  out  1  held line matches lk_addr[31:OFFSET_BITS]; combinational
- busy  out  1  entry valid, i.e. state != IDLE
- awvalid / awready  out / in  1 / 1  write address handshake
- awaddr  out  32  held line base address
- awlen  out  8  constant LINE_WORDS-1
- awsize  out  3  constant 3'b010
- awburst  out  2  constant 2'b01 (INCR)
- wvalid / wready  out / in  1 / 1  write data handshake
- wdata  out  32  current beat word
- wstrb  out  4  constant 4'hF
- wlast  out  1  final beat of the burst
- bvalid  in  1  write response valid; bresp is not used
- bready  out  1  response accept

## Operation
- State machine states: IDLE, AW, W, B.
- IDLE
  - vb_ready=1; all other handshake outputs are 0.
  - vb_push captures the address (offset bits zeroed) and all line words, sets valid, and moves to AW.
- AW
  - awvalid=1, held until awready.
  - On handshake: clear the beat counter and move to W.
- W
  - wvalid=1; wdata = word[beat]; wlast = (beat==LINE_WORDS-1).
  - On wready: increment beat. If the accepted beat was the last one, move to B.
  - wvalid stays high across beats; gaps come only from wready back-pressure.
- B
  - bready=1.
  - On bvalid: clear valid and move to IDLE.
- vb_ready is 1 only in IDLE. A push outside IDLE is ignored and must not corrupt the held line. The dcache is responsible for never doing this.
- lk_hit = valid && (lk_addr[31:OFFSET_BITS] == held_addr[31:OFFSET_BITS]).
  - Valid from the cycle after capture through the cycle of the bvalid handshake inclusive.
  - In IDLE, lk_hit=0.
- Beat counter is $clog2(LINE_WORDS) bits wide and never wraps within a burst.
- awaddr, wdata, awlen and the other constants are stable while their valid is high (AXI rule).
- Reset:
  - Every state returns to IDLE, valid=0 and beat=0 on the next edge.
  - Output values after reset: vb_ready=1; lk_hit=0; busy=0; awvalid=0; wvalid=0; wlast=0; bready=0.
  - awaddr and wdata reset to 0.
  - Reset mid-burst aborts the burst. The interconnect is reset together with the block.

## Timing
- Push accepted at edge N; awvalid=1 and lk_hit-capable from cycle N+1.
- With zero-wait slave (awready, wready, bvalid all high):
  - AW handshake at cycle N+1.
  - W beats in cycles N+2 .. N+1+LINE_WORDS.
  - B handshake in cycle N+2+LINE_WORDS.
  - vb_ready=1 again in cycle N+3+LINE_WORDS. For LINE_WORDS=8: push at 0, ready again at 11.
- No same-cycle push on the bvalid completion cycle; vb_ready is a pure state decode.
- lk_hit is combinational from lk_addr and registered state, with no added latency.
- Outputs depend only on registered state, except lk_hit.

## Test plan
- Basic drain, zero-wait slave:
  - Stimulus: push addr 0x1000_0024, data words 0x11..0x88.
  - Response: awaddr=0x1000_0020, awlen=7, awsize=2, awburst=1.
  - wdata 0x11,0x22,…,0x88 on consecutive cycles; wlast only with 0x88; vb_ready back at cycle 11.
- Back-pressure:
  - Stimulus: awready low for 3 cycles; wready toggling 1,0,1,0…; bvalid delayed 5 cycles.
  - Response: awaddr/wdata held stable while stalled; exactly 8 beats delivered in order; busy=1 until the bvalid handshake.
- Lookup:
  - Stimulus: with 0x2000_0040 held, lk_addr=0x2000_005C, then lk_addr=0x2000_0060.
  - Response: lk_hit=1 for 0x2000_005C and 0 for 0x2000_0060.
  - lk_hit stays 1 through the B cycle and is 0 the cycle after.
- Illegal push:
  - Stimulus: vb_push with different data during W.
  - Response: ignored; the burst carries the original data; vb_ready=0 throughout.
- Reset mid-operation:
  - Stimulus: rst asserted at beat 4.
  - Response: next cycle state is IDLE, wvalid=0, lk_hit=0, vb_ready=1.
  - A new push then drains cleanly from beat 0.
- Back-to-back lines:
  - Stimulus: two pushes, the second issued in the first cycle vb_ready returns.
  - Response: two complete bursts to the correct addresses; no beat lost or duplicated.
